// File: rtl/wam_pkg.sv
// wam_pkg: shared constants, types and helpers for the Whac-A-Mole
// seven-segment scan controller (wam_scan and wam_prescale).
//   - NDIG / AN_OFF      : display geometry and the all-anodes-off pattern
//   - DIG_*              : digit index constants (score low/high, timer low/high)
//   - *_DEF              : default timing parameters for the real board clock
//   - snap_t             : frame snapshot of score and timer
//   - digit_sel / an_sel : nibble selection and active-low anode one-hot
package wam_pkg;

  localparam int NDIG = 4;
  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef logic [1:0] dig_idx_t;

  localparam dig_idx_t DIG_SL = 2'd0;  // score low nibble
  localparam dig_idx_t DIG_SH = 2'd1;  // score high nibble
  localparam dig_idx_t DIG_TL = 2'd2;  // timer low nibble
  localparam dig_idx_t DIG_TH = 2'd3;  // timer high nibble

  localparam int SCAN_DIV_DEF    = 50000;
  localparam int GAP_DEF         = 500;
  localparam int BLINK_SLOTS_DEF = 400;
  localparam int DIV_W_DEF       = 16;

  typedef struct packed {
    logic [7:0] score;
    logic [7:0] timer;
  } snap_t;

  // Nibble shown on digit idx, taken from the frame snapshot.
  function automatic logic [3:0] digit_sel(input snap_t s, input dig_idx_t idx);
    logic [3:0] nib;
    case (idx)
      DIG_SL:  nib = s.score[3:0];
      DIG_SH:  nib = s.score[7:4];
      DIG_TL:  nib = s.timer[3:0];
      default: nib = s.timer[7:4];
    endcase
    return nib;
  endfunction

  // Active-low anode pattern selecting exactly digit idx.
  function automatic logic [3:0] an_sel(input dig_idx_t idx);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    return ~onehot;
  endfunction

endpackage

// File: rtl/wam_prescale.sv
// wam_prescale: slot prescaler for the display scan.
// Counts 0..SCAN_DIV-1 and wraps; tick_o marks the last cycle of a slot.
//   clk_i      : system clock
//   rst_i      : synchronous active-high reset
//   tick_o     : high while the count equals SCAN_DIV-1
//   cnt_next_o : count value the prescaler will hold after this edge
module wam_prescale #(
  parameter int SCAN_DIV = 50000,
  parameter int DIV_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             tick_o,
  output logic [DIV_W-1:0] cnt_next_o
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] ONE  = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Next count: increment, wrapping to zero after the last cycle of the slot.
  always_comb begin
    cnt_d = cnt_q + ONE;
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o     = (cnt_q == LAST);
  assign cnt_next_o = cnt_d;

endmodule

// File: rtl/wam_scan.sv
// wam_scan: time-multiplexed scan controller for the 4-digit display.
// Digits 0-1 show the score, digits 2-3 the countdown timer. Each digit owns
// a slot of SCAN_DIV cycles whose first GAP cycles keep all anodes off.
// Inputs are snapshotted once per frame so a digit pair never tears.
//   clk         : system clock
//   rst         : synchronous active-high reset
//   score/timer : two-nibble values, shown as-is
//   lzb_en      : blank zero high nibbles (digits 1 and 3)
//   blink_en    : blink the whole display every BLINK_SLOTS slots
//   an          : active-low anodes, at most one low
//   dnum        : nibble for the external segment decoder
//   frame_start : one-cycle pulse in the first cycle of slot 0
module wam_scan
  import wam_pkg::*;
#(
  parameter int SCAN_DIV    = SCAN_DIV_DEF,
  parameter int GAP         = GAP_DEF,
  parameter int BLINK_SLOTS = BLINK_SLOTS_DEF,
  parameter int DIV_W       = DIV_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] score,
  input  logic [7:0] timer,
  input  logic       lzb_en,
  input  logic       blink_en,
  output logic [3:0] an,
  output logic [3:0] dnum,
  output logic       frame_start
);

  localparam int BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
  localparam logic [BW-1:0]    BLAST = BW'(BLINK_SLOTS - 1);
  localparam logic [BW-1:0]    BONE  = BW'(1);
  localparam logic [DIV_W-1:0] GAP_C = DIV_W'(GAP);

  logic             slot_tick;
  logic [DIV_W-1:0] presc_next;

  dig_idx_t    idx_q,   idx_d;
  snap_t       snap_q,  snap_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic        bph_q,   bph_d;
  logic        fs_q,    fs_d;
  logic [3:0]  an_q,    an_d;
  logic [3:0]  dnum_q,  dnum_d;
  logic        blank;

  wam_prescale #(
    .SCAN_DIV (SCAN_DIV),
    .DIV_W    (DIV_W)
  ) u_presc (
    .clk_i      (clk),
    .rst_i      (rst),
    .tick_o     (slot_tick),
    .cnt_next_o (presc_next)
  );

  // Slot sequencing, frame snapshot and blink timing.
  always_comb begin
    idx_d  = idx_q;
    snap_d = snap_q;
    fs_d   = 1'b0;
    bcnt_d = bcnt_q;
    bph_d  = bph_q;

    if (slot_tick) begin
      idx_d = idx_q + 2'd1;
      // Latch the inputs only at the 3->0 wrap so a whole frame is coherent.
      if (idx_q == DIG_TH) begin
        snap_d.score = score;
        snap_d.timer = timer;
        fs_d         = 1'b1;
      end else begin
        snap_d = snap_q;
      end
    end else begin
      idx_d = idx_q;
    end

    // Blink is parked at visible while disabled so enabling starts lit.
    if (!blink_en) begin
      bcnt_d = '0;
      bph_d  = 1'b1;
    end else if (slot_tick) begin
      if (bcnt_q == BLAST) begin
        bcnt_d = '0;
        bph_d  = ~bph_q;
      end else begin
        bcnt_d = bcnt_q + BONE;
      end
    end else begin
      bcnt_d = bcnt_q;
    end
  end

  // Output decode from next state so the registered pins line up with the slot.
  always_comb begin
    dnum_d = digit_sel(snap_d, idx_d);
    blank  = 1'b0;
    an_d   = AN_OFF;

    // Only high nibbles are zero-blanked so a plain "0" still shows.
    blank = (lzb_en && (idx_d == DIG_SH) && (snap_d.score[7:4] == 4'h0)) ||
            (lzb_en && (idx_d == DIG_TH) && (snap_d.timer[7:4] == 4'h0)) ||
            (blink_en && !bph_d);

    if ((presc_next < GAP_C) || blank) begin
      an_d = AN_OFF;
    end else begin
      an_d = an_sel(idx_d);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= DIG_SL;
      snap_q <= '0;
      bcnt_q <= '0;
      bph_q  <= 1'b1;
      fs_q   <= 1'b0;
      an_q   <= AN_OFF;
      dnum_q <= 4'h0;
    end else begin
      idx_q  <= idx_d;
      snap_q <= snap_d;
      bcnt_q <= bcnt_d;
      bph_q  <= bph_d;
      fs_q   <= fs_d;
      an_q   <= an_d;
      dnum_q <= dnum_d;
    end
  end

  assign an          = an_q;
  assign dnum        = dnum_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_wam_scan.sv
module tb_wam_scan;

  localparam int SD = 4;
  localparam int G  = 1;
  localparam int BS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] score;
  logic [7:0] timer;
  logic       lzb_en;
  logic       blink_en;
  logic [3:0] an;
  logic [3:0] dnum;
  logic       frame_start;

  int checks = 0;
  int errors = 0;

  wam_scan #(
    .SCAN_DIV    (SD),
    .GAP         (G),
    .BLINK_SLOTS (BS),
    .DIV_W       (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .score       (score),
    .timer       (timer),
    .lzb_en      (lzb_en),
    .blink_en    (blink_en),
    .an          (an),
    .dnum        (dnum),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Reference model of the scan state, written in current-state form.
  logic       m_rst = 1'b1;
  int         m_p   = 0;
  int         m_i   = 0;
  int         m_bc  = 0;
  logic       m_bp  = 1'b1;
  logic [7:0] m_ss  = 8'h00;
  logic [7:0] m_st  = 8'h00;
  logic       m_fs  = 1'b0;
  logic       m_lz  = 1'b0;
  logic       m_bl  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_rst <= 1'b1; m_p <= 0; m_i <= 0; m_bc <= 0; m_bp <= 1'b1;
      m_ss <= 8'h00; m_st <= 8'h00; m_fs <= 1'b0; m_lz <= 1'b0; m_bl <= 1'b0;
    end else begin
      m_rst <= 1'b0;
      m_lz  <= lzb_en;
      m_bl  <= blink_en;
      m_p   <= (m_p == SD - 1) ? 0 : m_p + 1;
      m_fs  <= (m_p == SD - 1) && (m_i == 3);
      if (m_p == SD - 1) begin
        m_i <= (m_i + 1) % 4;
        if (m_i == 3) begin
          m_ss <= score;
          m_st <= timer;
        end
      end
      if (!blink_en) begin
        m_bc <= 0;
        m_bp <= 1'b1;
      end else if (m_p == SD - 1) begin
        if (m_bc == BS - 1) begin
          m_bc <= 0;
          m_bp <= !m_bp;
        end else begin
          m_bc <= m_bc + 1;
        end
      end
    end
  end

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] dn;
    logic       fs;
    logic       gap;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: push the model's expectation after the edge, compare at negedge.
  task automatic step();
    exp_t       e;
    logic [15:0] both;
    logic       blank;
    @(posedge clk);
    #1;
    both  = {m_st, m_ss} >> (4 * m_i);
    blank = (m_lz && m_i == 1 && m_ss[7:4] == 4'h0) ||
            (m_lz && m_i == 3 && m_st[7:4] == 4'h0) || (m_bl && !m_bp);
    e.dn  = m_rst ? 4'h0 : both[3:0];
    e.an  = (m_rst || m_p < G || blank) ? 4'hF : ~(4'h1 << m_i);
    e.fs  = m_fs;
    e.gap = (m_p < G);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk("sb_an", an, e.an);
    chk("sb_dnum", dnum, e.dn);
    chk("sb_fs", {3'b000, frame_start}, {3'b000, e.fs});
    chk("onehot", {3'b000, ($countones(~an) <= 1)}, 4'h1);
    if (e.gap) chk("gap_off", an, 4'hF);
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      step();
      n++;
    end while (!frame_start && n < 40);
    chk("frame_seen", {3'b000, frame_start}, 4'h1);
  endtask

  logic [3:0] dn_tbl [4] = '{4'h7, 4'h3, 4'h5, 4'h2};
  logic [3:0] lz_an  [4] = '{4'b1110, 4'b1111, 4'b1011, 4'b1111};
  logic [3:0] lz_dn  [4] = '{4'h5, 4'h0, 4'h9, 4'h0};
  logic       bl_on  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    rst = 1'b1; score = 8'h37; timer = 8'h25; lzb_en = 1'b0; blink_en = 1'b0;
    step(); step();
    chk("rst_an", an, 4'hF);
    chk("rst_dnum", dnum, 4'h0);
    chk("rst_fs", {3'b000, frame_start}, 4'h0);
    rst = 1'b0;

    // Normal scan of 37/25: full frame pattern and 16-cycle frame period.
    wait_frame();
    for (int k = 0; k < 16; k++) begin
      if (k > 0) step();
      chk("scan_an", an, (k % 4 == 0) ? 4'hF : ~(4'h1 << (k / 4)));
      chk("scan_dnum", dnum, dn_tbl[k / 4]);
    end
    step();
    chk("frame_period", {3'b000, frame_start}, 4'h1);

    // Score change mid-slot 1 stays hidden until the next frame.
    repeat (5) step();
    score = 8'h42;
    step();
    chk("notear_sh", dnum, 4'h3);
    wait_frame();
    chk("newframe_sl", dnum, 4'h2);
    repeat (4) step();
    chk("newframe_sh", dnum, 4'h4);

    // Leading-zero blanking on 05/09.
    lzb_en = 1'b1; score = 8'h05; timer = 8'h09;
    wait_frame();
    for (int k = 1; k < 16; k++) begin
      step();
      if (k % 4 == 2) begin
        chk("lzb_an", an, lz_an[k / 4]);
        chk("lzb_dnum", dnum, lz_dn[k / 4]);
      end
    end
    score = 8'h00;
    wait_frame();
    step(); step();
    chk("lzb_zero_an", an, 4'b1110);
    chk("lzb_zero_dnum", dnum, 4'h0);

    // Blink: two slots lit, two slots dark.
    lzb_en = 1'b0; score = 8'h37; timer = 8'h25;
    wait_frame();
    blink_en = 1'b1;
    for (int s = 0; s < 8; s++) begin
      repeat ((s == 0) ? 2 : 4) step();
      chk("blink_an", an, bl_on[s] ? ~(4'h1 << (s % 4)) : 4'hF);
    end
    blink_en = 1'b0;
    step();
    chk("blink_off_lit", an, 4'b0111);

    // Reset in slot 2 with prescaler at 2.
    wait_frame();
    repeat (10) step();
    rst = 1'b1;
    step();
    chk("midrst_an", an, 4'hF);
    chk("midrst_dnum", dnum, 4'h0);
    rst = 1'b0;
    step();
    chk("restart_an", an, 4'b1110);
    chk("restart_dnum", dnum, 4'h0);
    repeat (14) step();
    chk("restart_nofs", {3'b000, frame_start}, 4'h0);
    step();
    chk("restart_fs", {3'b000, frame_start}, 4'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
